// File: rtl/mem_arb_pkg.sv
// Shared types and reset constants for the unified-memory arbiter.
// Owner encoding is also used as the select value of mem_arb_sel.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [31:0] RST_WORD = 32'h0000_0000;
  localparam logic [3:0]  RST_MASK = 4'h0;
  localparam logic [3:0]  FULL_MASK = 4'hF;

endpackage

// File: rtl/mem_arb_sel.sv
// Owner selection for mem_arb: DM has priority over IF.
// With MEM_ARB_STARVE_GUARD_EN defined, a streak counter forces IF after STARVE_MAX DM wins.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant,
  output logic owner
);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] streak;
  logic          force_if;

  assign force_if = if_req && (streak == SW'(STARVE_MAX));

  always_comb begin
    owner = OWN_IF;
    if (dm_req && !force_if) owner = OWN_DM;
  end

  // streak only grows while IF is actually waiting behind a DM grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      streak <= '0;
    end else if (grant) begin
      if (owner == OWN_IF || !if_req) streak <= '0;
      else                            streak <= streak + SW'(1);
    end
  end
`else
  localparam int unused_starve = STARVE_MAX;
  logic unused_sel;
  assign unused_sel = ^{i_clk, i_rst, grant, if_req};

  always_comb begin
    owner = OWN_IF;
    if (dm_req) owner = OWN_DM;
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// Optional IF starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_vld,
  output logic [31:0] o_if_rdata,
  output logic        o_if_hold,
  input  logic        i_flush,
  input  logic        i_dm_req,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_gnt,
  output logic        o_dm_vld,
  output logic [31:0] o_dm_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a requester holds req and its payload; gnt pulses in the cycle the
  // request is sampled, vld pulses once when the access completes.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner_q, sel_owner;
  logic          wen_q;
  logic          flushed, flushed_nxt;
  logic          grant;
  logic [31:0]   rdata_q, addr_q, wdata_q;
  logic [3:0]    mask_q;

  assign grant = (state == IDLE) && (i_if_req || i_dm_req) && !i_rst;

  mem_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .if_req (i_if_req),
    .dm_req (i_dm_req),
    .grant  (grant),
    .owner  (sel_owner)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:  if (grant) state_nxt = ISSUE;
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = CW'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush only matters while an IF access is accepted or in flight
  always_comb begin
    flushed_nxt = flushed;
    if (i_flush && ((grant && sel_owner == OWN_IF) ||
                    (state != IDLE && owner_q == OWN_IF)))
      flushed_nxt = 1'b1;
    if (state == RESP) flushed_nxt = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      owner_q <= OWN_IF;
      wen_q   <= 1'b0;
      flushed <= 1'b0;
      addr_q  <= RST_WORD;
      wdata_q <= RST_WORD;
      mask_q  <= RST_MASK;
      rdata_q <= RST_WORD;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      flushed <= flushed_nxt;
      if (grant) begin
        owner_q <= sel_owner;
        if (sel_owner == OWN_DM) begin
          wen_q   <= i_dm_wen;
          addr_q  <= i_dm_addr;
          wdata_q <= i_dm_wdata;
          mask_q  <= i_dm_mask;
        end else begin
          wen_q  <= 1'b0;
          addr_q <= i_if_addr;
          mask_q <= FULL_MASK;
        end
      end
      if (state == WAIT && cnt == '0) rdata_q <= i_mem_rdata;
    end
  end

  assign o_if_gnt    = grant && (sel_owner == OWN_IF);
  assign o_dm_gnt    = grant && (sel_owner == OWN_DM);
  assign o_if_vld    = (state == RESP) && (owner_q == OWN_IF) && !flushed && !i_flush;
  assign o_dm_vld    = (state == RESP) && (owner_q == OWN_DM);
  assign o_if_rdata  = rdata_q;
  assign o_dm_rdata  = rdata_q;
  assign o_if_hold   = i_if_req && !o_if_vld;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;
  assign o_mem_ren   = (state == ISSUE) && !wen_q;
  assign o_mem_wen   = (state == ISSUE) && wen_q;
  assign o_dbg_state = state;

endmodule
